// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the processor execution-stage ALU.
//   ALU_W       : datapath width (16)
//   ALU_SEL_W   : operation select width (3)
//   alu_op_e    : opcode encoding carried on the S select lines
//   alu_flags_t : packed status flags {z, n, c, v}
//   op_sets_cv  : true for the opcodes whose carry/overflow flags are meaningful
// Optional feature macro used by the files that import this package:
//   ALU_FLAGS_EN  (adds the Z/N/C/V status flags)
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int ALU_W     = 16;
    localparam int ALU_SEL_W = 3;

    // Every 3-bit code is a real operation, so there is no illegal encoding.
    typedef enum logic [ALU_SEL_W-1:0] {
        OP_CLR   = 3'd0,
        OP_ADD   = 3'd1,
        OP_SUB   = 3'd2,
        OP_PASSA = 3'd3,
        OP_XOR   = 3'd4,
        OP_OR    = 3'd5,
        OP_AND   = 3'd6,
        OP_INC   = 3'd7
    } alu_op_e;

    typedef struct packed {
        logic z;
        logic n;
        logic c;
        logic v;
    } alu_flags_t;

    // Only the adder-based operations produce a carry/borrow or an overflow.
    // Logic operations, CLR and PASSA always report C=0 and V=0.
    function automatic logic op_sets_cv(alu_op_e op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_INC);
    endfunction

endpackage : alu_pkg

// File: rtl/alu_core.sv
// ---------------------------------------------------------------------------
// alu_core
// Purely combinational half of the ALU: computes the 16-bit result (and,
// when ALU_FLAGS_EN is defined, the Z/N/C/V status flags) from A, B and S.
// Holds no state; the top level registers everything.
// Ports:
//   A      in  16  operand A
//   B      in  16  operand B
//   S      in  3   operation select (alu_op_e encoding)
//   result out 16  unregistered result
//   flags  out 4   unregistered {z,n,c,v}  (only with ALU_FLAGS_EN)
// Configuration macro: ALU_FLAGS_EN
// ---------------------------------------------------------------------------
module alu_core
    import alu_pkg::*;
(
    input  logic [ALU_W-1:0]     A,
    input  logic [ALU_W-1:0]     B,
    input  logic [ALU_SEL_W-1:0] S,
`ifdef ALU_FLAGS_EN
    output alu_flags_t           flags,
`endif
    output logic [ALU_W-1:0]     result
);

    alu_op_e op;

    assign op = alu_op_e'(S);

    // Main result mux. All arithmetic is modulo 2^16, so plain 16-bit
    // operators give the required silent wrap-around for ADD, SUB and INC.
    // The result is cleared first so every path assigns it.
    always_comb begin
        result = '0;
        case (op)
            OP_CLR:   result = '0;
            OP_ADD:   result = A + B;
            OP_SUB:   result = A - B;
            OP_PASSA: result = A;
            OP_XOR:   result = A ^ B;
            OP_OR:    result = A | B;
            OP_AND:   result = A & B;
            OP_INC:   result = A + 16'd1;
        endcase
    end

`ifdef ALU_FLAGS_EN
    logic [ALU_W:0] add_ext;
    logic [ALU_W:0] sub_ext;
    logic [ALU_W:0] inc_ext;
    logic           carry_raw;
    logic           ovf_raw;

    // Zero-extended 17-bit versions of the adder operations. Bit 16 is the
    // carry out for ADD/INC; for SUB the 17-bit difference goes negative
    // exactly when A < B unsigned, so bit 16 is directly the borrow.
    assign add_ext = {1'b0, A} + {1'b0, B};
    assign sub_ext = {1'b0, A} - {1'b0, B};
    assign inc_ext = {1'b0, A} + 17'd1;

    // Carry and signed overflow for the adder-based ops. Signed overflow
    // happens when the operands agree in sign (for SUB: disagree, since B is
    // effectively negated) and the result sign differs from A's sign. For INC
    // the second operand is +1, so only A=0x7FFF can overflow.
    always_comb begin
        carry_raw = 1'b0;
        ovf_raw   = 1'b0;
        case (op)
            OP_ADD: begin
                carry_raw = add_ext[ALU_W];
                ovf_raw   = (A[ALU_W-1] == B[ALU_W-1]) &&
                            (add_ext[ALU_W-1] != A[ALU_W-1]);
            end
            OP_SUB: begin
                carry_raw = sub_ext[ALU_W];
                ovf_raw   = (A[ALU_W-1] != B[ALU_W-1]) &&
                            (sub_ext[ALU_W-1] != A[ALU_W-1]);
            end
            OP_INC: begin
                carry_raw = inc_ext[ALU_W];
                ovf_raw   = !A[ALU_W-1] && inc_ext[ALU_W-1];
            end
            default: begin
                carry_raw = 1'b0;
                ovf_raw   = 1'b0;
            end
        endcase
    end

    // Z and N come straight from the final result for every opcode; C and V
    // are masked so that only the adder-based ops can ever raise them.
    always_comb begin
        flags.z = (result == '0);
        flags.n = result[ALU_W-1];
        flags.c = op_sets_cv(op) && carry_raw;
        flags.v = op_sets_cv(op) && ovf_raw;
    end
`endif

endmodule : alu_core

// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu
// 16-bit, eight-function ALU used as the processor's execution stage.
// The combinational core computes the result from A, B, S; this level
// registers it (one cycle latency, one op per cycle, no handshake).
// Ports:
//   clk    in  1   system clock, rising edge
//   reset  in  1   synchronous active-high reset, clears Q (and flags)
//   A      in  16  operand A
//   B      in  16  operand B (ignored for CLR, PASSA, INC)
//   S      in  3   operation select: 0 CLR, 1 ADD, 2 SUB, 3 PASSA,
//                  4 XOR, 5 OR, 6 AND, 7 INC
//   Q      out 16  registered result
//   Z,N,C,V out 1  registered zero/negative/carry/overflow flags
//                  (only when ALU_FLAGS_EN is defined)
// Configuration macro: ALU_FLAGS_EN
// ---------------------------------------------------------------------------
module alu
    import alu_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ALU_W-1:0]     A,
    input  logic [ALU_W-1:0]     B,
    input  logic [ALU_SEL_W-1:0] S,
`ifdef ALU_FLAGS_EN
    output logic                 Z,
    output logic                 N,
    output logic                 C,
    output logic                 V,
`endif
    output logic [ALU_W-1:0]     Q
);

    logic [ALU_W-1:0] core_result;

`ifdef ALU_FLAGS_EN
    alu_flags_t core_flags;
    alu_flags_t flags_q;
`endif

    alu_core u_core (
        .A      (A),
        .B      (B),
        .S      (S),
`ifdef ALU_FLAGS_EN
        .flags  (core_flags),
`endif
        .result (core_result)
    );

    // Result register. Reset has priority over whatever operation is
    // selected, and the first real result appears one edge after reset
    // drops because the core output is simply captured every cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            Q <= '0;
        end else begin
            Q <= core_result;
        end
    end

`ifdef ALU_FLAGS_EN
    // Flags are registered in lockstep with Q so downstream compare/branch
    // logic sees result and status from the same operation.
    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q <= '0;
        end else begin
            flags_q <= core_flags;
        end
    end

    assign Z = flags_q.z;
    assign N = flags_q.n;
    assign C = flags_q.c;
    assign V = flags_q.v;
`endif

endmodule : alu

// File: tb/tb_alu.sv
// ---------------------------------------------------------------------------
// tb_alu
// Self-checking bench for alu. A behavioural model (plain integer
// arithmetic) predicts Q and, with ALU_FLAGS_EN, the flags; a negedge
// compare process checks the DUT every cycle. Directed vectors carry
// hand-computed literals that also pin the model.
// ---------------------------------------------------------------------------
module tb_alu;

    logic        clk;
    logic        reset;
    logic [15:0] A;
    logic [15:0] B;
    logic [2:0]  S;
    logic [15:0] Q;
`ifdef ALU_FLAGS_EN
    logic        Z;
    logic        N;
    logic        C;
    logic        V;
`endif

    int          n_vectors;
    int          n_miscompares;
    logic        exp_valid;
    logic [15:0] exp_q;
    logic [3:0]  exp_flags;

    alu dut (
        .clk   (clk),
        .reset (reset),
        .A     (A),
        .B     (B),
        .S     (S),
`ifdef ALU_FLAGS_EN
        .Z     (Z),
        .N     (N),
        .C     (C),
        .V     (V),
`endif
        .Q     (Q)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference result straight from the opcode table, using wide integers
    // and keeping the low 16 bits to get modulo-2^16 behaviour.
    function automatic logic [15:0] model_q(int s, int a, int b);
        int r;
        case (s)
            0:       r = 0;
            1:       r = a + b;
            2:       r = a - b;
            3:       r = a;
            4:       r = a ^ b;
            5:       r = a | b;
            6:       r = a & b;
            default: r = a + 1;
        endcase
        return r[15:0];
    endfunction

    // Reference flags {z,n,c,v}: carry from the unsigned sum exceeding 16
    // bits, borrow from an unsigned compare, overflow from the true signed
    // result falling outside the 16-bit two's-complement range.
    function automatic logic [3:0] model_flags(int s, int a, int b);
        logic [15:0] q;
        int          sa;
        int          sb;
        int          sr;
        logic        c;
        logic        v;
        q  = model_q(s, a, b);
        sa = (a >= 32768) ? a - 65536 : a;
        sb = (b >= 32768) ? b - 65536 : b;
        c  = 1'b0;
        v  = 1'b0;
        sr = 0;
        if (s == 1) begin
            c  = (a + b) > 65535;
            sr = sa + sb;
            v  = (sr > 32767) || (sr < -32768);
        end else if (s == 2) begin
            c  = a < b;
            sr = sa - sb;
            v  = (sr > 32767) || (sr < -32768);
        end else if (s == 7) begin
            c  = (a + 1) > 65535;
            sr = sa + 1;
            v  = (sr > 32767) || (sr < -32768);
        end
        return {q == 16'h0000, q[15], c, v};
    endfunction

    // Compares the registered outputs against the current expectation.
    task automatic checkOutput();
        n_vectors++;
        if (Q !== exp_q) begin
            n_miscompares++;
            $display("[TB] FAIL q: S=%0d A=%h B=%h got Q=%h expected %h",
                     S, A, B, Q, exp_q);
        end
`ifdef ALU_FLAGS_EN
        n_vectors++;
        if ({Z, N, C, V} !== exp_flags) begin
            n_miscompares++;
            $display("[TB] FAIL flags: got ZNCV=%b expected %b", {Z, N, C, V}, exp_flags);
        end
`endif
    endtask

    // Drives one operation, waits for the capturing edge, then publishes
    // what the registered outputs must now show.
    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                                 input logic [2:0] s, input logic rst);
        A     = a;
        B     = b;
        S     = s;
        reset = rst;
        @(posedge clk);
        #1;
        exp_q     = rst ? 16'h0000 : model_q(int'(s), int'(a), int'(b));
        exp_flags = rst ? 4'b0000 : model_flags(int'(s), int'(a), int'(b));
        exp_valid = 1'b1;
    endtask

    // Directed vector with hand-computed literals; the model is checked
    // against the literals before the DUT is checked against them.
    task automatic applyDirected(input logic [15:0] a, input logic [15:0] b,
                                 input logic [2:0] s, input logic rst,
                                 input logic [15:0] lit_q,
                                 input logic [3:0] lit_flags, input logic use_flags);
        if (!rst) begin
            n_vectors++;
            if (model_q(int'(s), int'(a), int'(b)) !== lit_q) begin
                n_miscompares++;
                $display("[TB] FAIL model_q pin: S=%0d A=%h B=%h got %h expected %h",
                         s, a, b, model_q(int'(s), int'(a), int'(b)), lit_q);
            end
            if (use_flags) begin
                n_vectors++;
                if (model_flags(int'(s), int'(a), int'(b)) !== lit_flags) begin
                    n_miscompares++;
                    $display("[TB] FAIL model_flags pin: S=%0d A=%h B=%h got %b expected %b",
                             s, a, b, model_flags(int'(s), int'(a), int'(b)), lit_flags);
                end
            end
        end
        applyStimulus(a, b, s, rst);
        exp_q = lit_q;
        if (use_flags) exp_flags = lit_flags;
    endtask

    // One compare per cycle, half a period after the capturing edge.
    always @(negedge clk) begin
        if (exp_valid) checkOutput();
    end

    initial begin
        n_vectors     = 0;
        n_miscompares = 0;
        exp_valid     = 1'b0;
        exp_q         = 16'h0000;
        exp_flags     = 4'b0000;
        reset         = 1'b1;
        A             = 16'h0000;
        B             = 16'h0000;
        S             = 3'd0;

        $display("[TB] reset and first result");
        applyDirected(16'h1234, 16'h0001, 3'd1, 1'b1, 16'h0000, 4'b0000, 1'b1);
        applyDirected(16'h1234, 16'h0001, 3'd1, 1'b0, 16'h1235, 4'b0000, 1'b1);

        $display("[TB] directed opcode and boundary vectors");
        applyDirected(16'h0003, 16'h0005, 3'd2, 1'b0, 16'hFFFE, 4'b0110, 1'b1);
        applyDirected(16'h0006, 16'h0003, 3'd6, 1'b0, 16'h0002, 4'b0000, 1'b1);
        applyDirected(16'hFFFF, 16'h0001, 3'd1, 1'b0, 16'h0000, 4'b1010, 1'b1);
        applyDirected(16'hFFFF, 16'h1234, 3'd7, 1'b0, 16'h0000, 4'b1010, 1'b1);
        applyDirected(16'h7FFF, 16'h0001, 3'd1, 1'b0, 16'h8000, 4'b0101, 1'b1);
        applyDirected(16'h0000, 16'h0001, 3'd2, 1'b0, 16'hFFFF, 4'b0110, 1'b1);
        applyDirected(16'hABCD, 16'hFFFF, 3'd0, 1'b0, 16'h0000, 4'b1000, 1'b1);
        applyDirected(16'h8001, 16'h5555, 3'd3, 1'b0, 16'h8001, 4'b0100, 1'b1);

        $display("[TB] back-to-back operations");
        applyDirected(16'h00F0, 16'h0F0F, 3'd1, 1'b0, 16'h0FFF, 4'b0000, 1'b1);
        applyDirected(16'h00F0, 16'h0F0F, 3'd2, 1'b0, 16'hF1E1, 4'b0110, 1'b1);
        applyDirected(16'h00F0, 16'h0F0F, 3'd4, 1'b0, 16'h0FFF, 4'b0000, 1'b1);
        applyDirected(16'h00F0, 16'h0F0F, 3'd5, 1'b0, 16'h0FFF, 4'b0000, 1'b1);

        $display("[TB] exhaustive small-operand sweep with one mid-stream reset");
        for (int s = 0; s < 8; s++) begin
            for (int a = 0; a < 8; a++) begin
                for (int b = 0; b < 8; b++) begin
                    applyStimulus(16'(a), 16'(b), 3'(s),
                                  (s == 4 && a == 3 && b == 0) ? 1'b1 : 1'b0);
                end
            end
        end

        $display("[TB] randomized vectors");
        for (int i = 0; i < 400; i++) begin
            applyStimulus(16'($urandom), 16'($urandom), 3'($urandom_range(0, 7)),
                          ($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0);
        end

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule : tb_alu

// File: doc/alu.md
# alu

16-bit, eight-function arithmetic/logic unit with a registered result, used as the datapath execution stage of the simple processor. Two 16-bit operands and a 3-bit select produce a 16-bit result, captured on the rising clock edge. Optional status flags can be compiled in for branch/compare logic downstream.

## Interface
- No parameters; data width fixed at 16, select width fixed at 3.
- clk    input   1   system clock; all state updates on rising edge.
- reset  input   1   synchronous, active-high reset.
- A      input   16  operand A (unsigned or two's-complement per op).
- B      input   16  operand B.
- S      input   3   operation select.
- Q      output  16  registered result.
- Z, N, C, V  output  1 each  zero/negative/carry/overflow flags; present only with ALU_FLAGS_EN.

## Operation
- Opcode map (S): 0 CLR Q=0; 1 ADD Q=A+B; 2 SUB Q=A-B; 3 PASSA Q=A; 4 XOR Q=A^B; 5 OR Q=A|B; 6 AND Q=A&B; 7 INC Q=A+1.
- All arithmetic modulo 2^16; wrap-around silent (0xFFFF+1 -> 0x0000; 0x0000-1 -> 0xFFFF).
- B ignored for ops 0, 3, 7; A ignored for op 0.
- No X-propagation tolerance required; every S value is defined, no default/illegal code.
- Next-state logic purely combinational from A, B, S; no internal state beyond output register(s).

## Timing
- Latency 1 cycle: Q at edge n+1 reflects A, B, S sampled at edge n.
- Throughput 1 op/cycle; new operands accepted every cycle, no handshake.
- reset high at an edge: Q=0x0000 (and all flags 0) regardless of A/B/S; reset dominates any operation.
- Reset deasserted: first result appears one edge after deassertion.
- Q holds value between edges; input changes mid-cycle have no effect on Q until next edge.

## Configuration
- ALU_FLAGS_EN defined: Z, N, C, V ports exist and are registered alongside Q, same latency.
  - Z = (result==0); N = result[15].
  - C: ADD/INC = carry out of bit 15; SUB = borrow (1 when A<B unsigned); 0 for logic/CLR/PASSA.
  - V: ADD/INC/SUB = signed two's-complement overflow; 0 otherwise.
- Not defined: flag ports and logic absent; Q behaviour identical.

## Structure
- Package alu_pkg: opcode enum alu_op_e (OP_CLR=0 ... OP_INC=7), width constants ALU_W=16, ALU_SEL_W=3.
- One sub-module natural: alu_core, purely combinational result (and flags) from A, B, S; top alu adds the output register and reset.

## Test plan
- Reset: reset=1 with A=0x1234, B=0x0001, S=1 -> Q=0x0000 after edge; deassert -> Q=0x1235 next edge.
- Opcode sweep: S=0..7, A=0..7, B=0..7 exhaustive -> Q matches opcode map one cycle later (e.g. S=2, A=3, B=5 -> 0xFFFE; S=6, A=6, B=3 -> 0x0002).
- Wrap: S=1, A=0xFFFF, B=0x0001 -> Q=0x0000 (Z=1, C=1 with flags); S=7, A=0xFFFF -> Q=0x0000.
- Signed overflow (flags): S=1, A=0x7FFF, B=0x0001 -> Q=0x8000, N=1, V=1, C=0; S=2, A=0x0000, B=0x0001 -> Q=0xFFFF, C=1.
- Back-to-back: change S every cycle 1,2,4,5 with A=0x00F0, B=0x0F0F -> Q sequence 0x0FFF, 0xF1E1, 0x0FFF, 0x0FFF, each one cycle late.
- Mid-stream reset: reset pulsed one cycle during sweep -> Q=0 that cycle, normal results resume next edge.
